// File: rtl/msk_pkg.sv
// Shared definitions for the share recombiner: sharing layout, FSM encoding,
// and the counter width helper.
package msk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Position of share s of plaintext bit b inside a d-share word.
    function automatic int share_idx(input int b, input int s, input int d);
        return b * d + s;
    endfunction

    // Counter must index shares 1..d-1; never narrower than one bit.
    function automatic int cnt_w(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/msk_share_acc_lane.sv
// One plaintext bit: holds shares 1..D-1 and folds one of them per step into
// a registered accumulator that starts from share 0.
module msk_share_acc_lane
    import msk_pkg::*;
#(
    parameter int D = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [D-1:0]          shares,
    input  logic                  load,
    input  logic                  step,
    input  logic                  clear,
    input  logic [cnt_w(D)-1:0]   cnt,
    output logic                  bit_out
);

    localparam int CW = cnt_w(D);

    logic [D-1:1] stored;
    logic         acc;
    logic         sel;

    always_comb begin
        sel = 1'b0;
        for (int j = 1; j < D; j++) begin
            if (cnt == CW'(j)) sel = stored[j];
        end
    end

    // Each consumed share slot is wiped so no share outlives its use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored <= '0;
            acc    <= 1'b0;
        end else if (clear) begin
            stored <= '0;
            acc    <= 1'b0;
        end else if (load) begin
            stored <= shares[D-1:1];
            acc    <= shares[0];
        end else if (step) begin
            acc <= acc ^ sel;
            for (int j = 1; j < D; j++) begin
                if (cnt == CW'(j)) stored[j] <= 1'b0;
            end
        end
    end

    assign bit_out = acc;

endmodule

// File: rtl/msk_unshare_seq.sv
// Sequential unmasking decoder: recombines a D-share Boolean word one share
// per cycle and releases the plaintext only while the result is offered.
module msk_unshare_seq
    import msk_pkg::*;
#(
    parameter int D = 2,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [D*W-1:0] in_shares,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           busy
);

    localparam int CW = cnt_w(D);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            load, step, clear;
    logic [W-1:0]    acc_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // flush outranks any accept or output handshake in the same cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        step     = 1'b0;
        clear    = 1'b0;
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            clear    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        load     = 1'b1;
                        cnt_nx   = CW'(1);
                        state_nx = ACC;
                    end
                end
                ACC: begin
                    step = 1'b1;
                    if (cnt == CW'(D - 1)) begin
                        cnt_nx   = '0;
                        state_nx = DONE;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        clear    = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: begin
                    clear    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_lane
        msk_share_acc_lane #(.D(D)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .shares (in_shares[share_idx(i, 0, D) +: D]),
            .load   (load),
            .step   (step),
            .clear  (clear),
            .cnt    (cnt),
            .bit_out(acc_bits[i])
        );
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = (state == DONE) ? acc_bits : '0;

endmodule

// File: doc/msk_unshare_seq.md
Name: msk_unshare_seq

Overview:
- Sequential share recombiner (unmasking decoder) for d-share Boolean sharings.
- Inverse direction of the share-domain gadgets: takes a masked W-bit word and produces its plaintext.
- Recombines one share per cycle through a registered accumulator, so no combinational XOR tree ever sees all shares of a bit at once.
- Sits at the tag/output boundary of the masked core; the only place plaintext leaves the share domain.

Parameters:
- d, 2, number of shares per bit; legal range d >= 2.
- W, 32, number of plaintext bits per word.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sharing on in_shares is valid.
- in_ready  output  1  block can accept a sharing.
- in_shares  input  d*W  masked word; bit i occupies [i*d +: d], share j of bit i at bit i*d+j.
- flush  input  1  synchronous abort; returns the block to IDLE.
- out_valid  output  1  out_data holds the recombined plaintext.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  W  plaintext, bit i = XOR over j of share j of bit i.
- busy  output  1  high in ACC or DONE.

Behaviour:
- One clock and an asynchronous active-low reset, rst_n; no other clock or reset inputs.
- Reset (rst_n low, asynchronous): state = IDLE.
  - Share register, accumulator and counter are cleared to 0.
  - in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
- States: IDLE, ACC, DONE. Registered controls: in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- IDLE:
  - Accept on in_valid && in_ready at edge T.
  - Capture shares 1..d-1 of every bit into the share register.
  - acc <= share 0 of every bit; cnt <= 1; go to ACC.
- ACC:
  - Each edge: acc <= acc ^ share[cnt] (per bit); the consumed share slot is zeroed; cnt <= cnt+1.
  - The edge with cnt == d-1 moves to DONE.
  - out_valid therefore rises after edge T+d-1, i.e. d-1 cycles after the accept edge.
  - For d = 2: one ACC cycle.
- DONE:
  - out_data = acc, held stable while out_valid && !out_ready.
  - On out_valid && out_ready at an edge: acc <= 0 (out_data zeroised), share register already zero, go to IDLE.
  - in_ready rises the following cycle, so throughput is one word per d+1 cycles minimum.
  - No overlap: in_valid is ignored outside IDLE.
- out_data is forced to 0 whenever state != DONE. Plaintext is never visible on the port otherwise.
- flush has priority over every other event in any state: next state IDLE, share register, acc and cnt cleared.
  - A simultaneous in_valid accept or out_ready handshake in the same cycle is discarded; no word is produced.
- Reset mid-operation: same clearing as flush, asynchronous; the partial result is lost.
- cnt width: clog2(d), saturating behaviour not required because the DONE transition at cnt == d-1 bounds it.
- Input protocol: the producer must hold in_shares stable while in_valid && !in_ready. The block samples only at the accept edge.
- Randomness: none consumed; the block is a decoder, not a refresh gadget.

Decomposition:
- Shared package msk_pkg holds:
  - the sharing bit-layout helper: index function bit*d+share;
  - the state encoding localparams IDLE/ACC/DONE;
  - the clog2-based counter width constant.
- One natural sub-module: msk_share_acc_lane, the per-bit lane.
  - Holds the d-1 stored shares and the accumulator bit.
  - Takes load/step/clear/cnt and outputs the recombined bit.
  - Instantiated W times by generate.
- The FSM and handshake stay in the top module.

Test Plan:
- d=3, W=8. Shares per bit give plaintext 0xA5 (share0=0x3C, share1=0x5F, share2=0xC6), out_ready=1 -> out_valid rises 2 cycles after accept, out_data=0xA5 for exactly one cycle, in_ready high the next cycle.
- Backpressure: d=2, W=8, plaintext 0xFF (shares 0x0F/0xF0), out_ready=0 for 5 cycles -> out_data holds 0xFF, in_valid pulses during those cycles are not accepted, in_ready stays 0.
- flush asserted in ACC (d=3, cycle after accept) -> next cycle state IDLE, in_ready=1, out_valid never rises, out_data stays 0x00.
- rst_n pulsed low in DONE with out_data=0x5A -> out_valid and out_data drop to 0 asynchronously, in_ready=1 after release.
- flush and out_ready both high in DONE -> flush wins, no further handshake, block returns to IDLE with out_data=0.
- Back-to-back stream, d=2: 4 random words with in_valid held high -> each output equals the XOR of its shares, accepts spaced exactly 3 cycles apart (d+1).
